// File: rtl/ma_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ma_stage
//  Purpose  : Memory-Access pipeline stage between Execute and Writeback.
//             Non-memory instructions pass through one output register.
//             Aligned loads and stores go to data memory over a valid/ready
//             request/response port. The stage stalls upstream until the
//             access completes. Misaligned loads and stores are flagged on
//             Ma_Err_o and never reach memory.
//  Ports    : Clk, Rst            - clock, synchronous active-high reset
//             Ex_*                - payload and handshake from Execute
//             Dmem_Req_* / Addr / We / Wdata - memory request channel
//             Dmem_Rsp_* / Rdata  - memory response channel
//             Ma_*                - payload and handshake toward Writeback
//  Revision : 1.0 - initial release
// ============================================================================
module ma_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    // Execute side
    input  logic              Ex_Valid_i,
    output logic              Ex_Ready_o,
    input  logic [31:0]       Ex_Pc_i,
    input  logic [DATA_W-1:0] Ex_AluResult_i,
    input  logic [DATA_W-1:0] Ex_Op2_i,
    input  logic [RD_W-1:0]   Ex_Rd_i,
    input  logic              Ex_IsLd_i,
    input  logic              Ex_IsSt_i,
    input  logic              Ex_IsWb_i,
    // Data memory request
    output logic              Dmem_Req_Valid_o,
    input  logic              Dmem_Req_Ready_i,
    output logic [ADDR_W-1:0] Dmem_Addr_o,
    output logic              Dmem_We_o,
    output logic [DATA_W-1:0] Dmem_Wdata_o,
    // Data memory response
    input  logic              Dmem_Rsp_Valid_i,
    output logic              Dmem_Rsp_Ready_o,
    input  logic [DATA_W-1:0] Dmem_Rdata_i,
    // Writeback side
    output logic              Ma_Valid_o,
    input  logic              Ma_Ready_i,
    output logic [31:0]       Ma_Pc_o,
    output logic [DATA_W-1:0] Ma_AluResult_o,
    output logic [DATA_W-1:0] Ma_LdResult_o,
    output logic [RD_W-1:0]   Ma_Rd_o,
    output logic              Ma_IsLd_o,
    output logic              Ma_IsWb_o,
    output logic              Ma_Err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Instruction held for the duration of a memory access
    logic [31:0]       r_hold_pc;
    logic [DATA_W-1:0] r_hold_alu;
    logic [DATA_W-1:0] r_hold_wdata;
    logic [DATA_W-1:0] r_hold_ldata;
    logic [RD_W-1:0]   r_hold_rd;
    logic              r_hold_isld;
    logic              r_hold_iswb;
    logic              r_hold_we;

    logic w_out_free;
    logic w_accept;
    logic w_is_mem;
    logic w_misalign;
    logic w_go_mem;
    logic w_direct;
    logic w_wb_fire;

    // The output register can take a new payload when empty or draining now
    assign w_out_free = !Ma_Valid_o || Ma_Ready_i;
    assign Ex_Ready_o = (r_state == ST_IDLE) && w_out_free;
    assign w_accept   = Ex_Valid_i && Ex_Ready_o;
    assign w_is_mem   = Ex_IsLd_i || Ex_IsSt_i;
    assign w_misalign = (Ex_AluResult_i[1:0] != 2'b00);
    assign w_go_mem   = w_accept && w_is_mem && !w_misalign;
    // Non-memory and misaligned instructions both complete in one cycle
    assign w_direct   = w_accept && !w_go_mem;
    assign w_wb_fire  = (r_state == ST_WB) && w_out_free;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_go_mem)         w_state_nxt = ST_REQ;
            ST_REQ:  if (Dmem_Req_Ready_i) w_state_nxt = ST_RESP;
            ST_RESP: if (Dmem_Rsp_Valid_i) w_state_nxt = ST_WB;
            ST_WB:   if (w_out_free)       w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_hold_pc    <= '0;
            r_hold_alu   <= '0;
            r_hold_wdata <= '0;
            r_hold_ldata <= '0;
            r_hold_rd    <= '0;
            r_hold_isld  <= 1'b0;
            r_hold_iswb  <= 1'b0;
            r_hold_we    <= 1'b0;
        end else begin
            if (w_go_mem) begin
                r_hold_pc    <= Ex_Pc_i;
                r_hold_alu   <= Ex_AluResult_i;
                r_hold_wdata <= Ex_Op2_i;
                r_hold_rd    <= Ex_Rd_i;
                r_hold_isld  <= Ex_IsLd_i;
                r_hold_iswb  <= Ex_IsWb_i;
                r_hold_we    <= !Ex_IsLd_i;
            end
            // Store acks carry no useful data, so only loads capture Rdata
            if ((r_state == ST_RESP) && Dmem_Rsp_Valid_i && r_hold_isld) begin
                r_hold_ldata <= Dmem_Rdata_i;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Ma_Valid_o     <= 1'b0;
            Ma_Pc_o        <= '0;
            Ma_AluResult_o <= '0;
            Ma_LdResult_o  <= '0;
            Ma_Rd_o        <= '0;
            Ma_IsLd_o      <= 1'b0;
            Ma_IsWb_o      <= 1'b0;
            Ma_Err_o       <= 1'b0;
        end else if (w_direct) begin
            // A memory op on this path is misaligned: flag it, suppress writeback
            Ma_Valid_o     <= 1'b1;
            Ma_Pc_o        <= Ex_Pc_i;
            Ma_AluResult_o <= Ex_AluResult_i;
            Ma_LdResult_o  <= '0;
            Ma_Rd_o        <= Ex_Rd_i;
            Ma_IsLd_o      <= Ex_IsLd_i;
            Ma_IsWb_o      <= Ex_IsWb_i && !w_is_mem;
            Ma_Err_o       <= w_is_mem;
        end else if (w_wb_fire) begin
            Ma_Valid_o     <= 1'b1;
            Ma_Pc_o        <= r_hold_pc;
            Ma_AluResult_o <= r_hold_alu;
            Ma_LdResult_o  <= r_hold_isld ? r_hold_ldata : '0;
            Ma_Rd_o        <= r_hold_rd;
            Ma_IsLd_o      <= r_hold_isld;
            Ma_IsWb_o      <= r_hold_isld && r_hold_iswb;
            Ma_Err_o       <= 1'b0;
        end else if (Ma_Valid_o && Ma_Ready_i) begin
            Ma_Valid_o     <= 1'b0;
        end
    end

    assign Dmem_Req_Valid_o = (r_state == ST_REQ);
    assign Dmem_Addr_o      = r_hold_alu[ADDR_W-1:0];
    assign Dmem_We_o        = r_hold_we;
    assign Dmem_Wdata_o     = r_hold_wdata;
    // Always sink responses; anything outside RESP is a stale leftover
    assign Dmem_Rsp_Ready_o = 1'b1;

endmodule
`default_nettype wire

// File: doc/ma_stage.md
Name: ma_stage

Overview:
- Memory-Access pipeline stage, directly downstream of the Execute stage, upstream of Register-Writeback.
- Accepts one executed instruction per handshake and passes non-memory instructions through a single output register.
- Loads and stores are issued to the data memory over a valid/ready request/response port; the stage stalls upstream until the access completes.
- Output feeds RW stage: ALU result, load result, destination register, writeback enable.

Parameters:
- ADDR_W, 32, data memory byte-address width (must be ≤32).
- DATA_W, 32, data word width (fixed 32 this revision).
- RD_W, 4, destination register index width.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Ex_Valid_i  in  1  EX payload valid.
- Ex_Ready_o  out  1  stage can accept EX payload.
- Ex_Pc_i  in  32  instruction PC.
- Ex_AluResult_i  in  32  ALU result; memory byte address for ld/st.
- Ex_Op2_i  in  32  store data.
- Ex_Rd_i  in  RD_W  destination register.
- Ex_IsLd_i  in  1  load instruction.
- Ex_IsSt_i  in  1  store instruction.
- Ex_IsWb_i  in  1  instruction writes a register.
- Dmem_Req_Valid_o  out  1  memory request valid.
- Dmem_Req_Ready_i  in  1  memory accepts request.
- Dmem_Addr_o  out  ADDR_W  byte address (ALU result, low ADDR_W bits).
- Dmem_We_o  out  1  1 = store, 0 = load.
- Dmem_Wdata_o  out  32  store data.
- Dmem_Rsp_Valid_i  in  1  response valid (load data or store ack).
- Dmem_Rsp_Ready_o  out  1  stage accepts response.
- Dmem_Rdata_i  in  32  load data.
- Ma_Valid_o  out  1  RW payload valid.
- Ma_Ready_i  in  1  RW accepts payload.
- Ma_Pc_o  out  32  PC.
- Ma_AluResult_o  out  32  ALU result.
- Ma_LdResult_o  out  32  load data (0 for non-loads).
- Ma_Rd_o  out  RD_W  destination register.
- Ma_IsLd_o  out  1  selects LdResult in RW.
- Ma_IsWb_o  out  1  writeback enable.
- Ma_Err_o  out  1  misaligned ld/st.

Behaviour:
- Reset (Rst=1 at edge): FSM → IDLE; every output register and Ma_* output cleared to 0; Dmem_Req_Valid_o=0. Reset mid-access abandons the access, with no retry.
- FSM states: IDLE, REQ, RESP, WB. Ex_Ready_o = (state==IDLE) && (!Ma_Valid_o || Ma_Ready_i).
- Output register: cleared Ma_Valid_o when Ma_Valid_o && Ma_Ready_i and no new load that cycle. Payload stable while Ma_Valid_o && !Ma_Ready_i.
- Accept (Ex_Valid_i && Ex_Ready_o), non-memory (IsLd=IsSt=0): output register loaded, Ma_Valid_o=1 next cycle (latency 1), LdResult=0, state stays IDLE; back-to-back accepts give full throughput.
- Accept, ld/st with AluResult[1:0]!=0: no memory request; output loaded next cycle with Ma_Err_o=1, Ma_IsWb_o=0; stays IDLE.
- Accept, aligned ld/st: fields latched into hold regs; → REQ.
- REQ: Dmem_Req_Valid_o=1; Addr/We/Wdata driven from hold regs, stable until Dmem_Req_Ready_i. On Req_Ready → RESP.
- RESP: Dmem_Rsp_Ready_o=1. On Dmem_Rsp_Valid_i, capture Rdata (loads) and → WB. Stores also wait for the response (ack); their data is ignored.
- WB: when !Ma_Valid_o || Ma_Ready_i, load output from hold regs (store: IsWb=0, LdResult=0) and → IDLE; else wait.
- Dmem_Rsp_Ready_o=1 also in IDLE, REQ and WB. Responses in those states are dropped (stale after reset).
- Dmem_Req_Valid_o=0 outside REQ. At most one outstanding access.
- Aligned load latency with zero-wait memory: accept T, req T+1, rsp T+2, WB T+3, Ma_Valid_o T+4.

Test Plan:
- Reset: Rst=1 two cycles with random inputs → all outputs 0, Ex_Ready_o=1 after release.
- Four back-to-back ALU ops (AluResult 0x10..0x13), Ma_Ready_i=1 → Ma_Valid_o every cycle from T+1, results in order, Ex_Ready_o constantly 1.
- Load addr 0x100, memory returns 0xDEADBEEF with 3-cycle Req_Ready delay → Addr stable 0x100 over the 3 stall cycles; Ma_LdResult_o=0xDEADBEEF, IsLd=1, IsWb=1; Ex_Ready_o=0 throughout.
- Store addr 0x204 data 0xCAFEF00D → one request with We=1 and Wdata=0xCAFEF00D; output IsWb=0, LdResult=0.
- Misaligned load addr 0x102 → no Dmem_Req_Valid_o, Ma_Err_o=1, IsWb=0 at T+1.
- Ma_Ready_i=0 for 5 cycles during load WB → payload held, Ex_Ready_o=0. Then assert Rst while in RESP and pulse Rsp_Valid in IDLE → response dropped, Ma_Valid_o stays 0.
